// File: rtl/pkt_indicator_bank.sv
// pkt_indicator_bank: per-channel packet-detect LED stretcher with optional hit counters.
// Define PKT_STAT_COUNT_EN to build the hit counters, hit_cnt readback and cnt_sat.
module pkt_indicator_bank #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 32_000_000,
    parameter int TIMER_W     = 25,
    parameter int CNT_W       = 16,
    parameter bit RETRIGGER   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  pkt_pulse,
    input  logic             clr_cnt,
    input  logic [3:0]       sel,
    output logic [N_CH-1:0]  led,
    output logic             active_any,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);
    localparam logic [0:0]         IDLE   = 1'b0;
    localparam logic [0:0]         HOLD   = 1'b1;
    localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(HOLD_CYCLES - 1);

    logic [N_CH-1:0]              pkt_q, state_q, state_d, ev;
    logic [N_CH-1:0][TIMER_W-1:0] timer_q, timer_d;
    logic                         run_q;

    // run_q blocks the first cycle after reset so an input already high is not an event
    assign ev = pkt_pulse & ~pkt_q & {N_CH{run_q & en}};

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            if (state_q[i] == IDLE) begin
                if (ev[i]) begin
                    state_d[i] = HOLD;
                    timer_d[i] = '0;
                end
            end else if (ev[i] && RETRIGGER) begin
                timer_d[i] = '0;
            end else if (timer_q[i] == T_LAST) begin
                state_d[i] = IDLE;
                timer_d[i] = '0;
            end else begin
                timer_d[i] = timer_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_q   <= '0;
            run_q   <= 1'b0;
            state_q <= '0;
            timer_q <= '0;
        end else begin
            pkt_q   <= pkt_pulse;
            run_q   <= 1'b1;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign led        = state_q;
    assign active_any = |state_q;

`ifdef PKT_STAT_COUNT_EN
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            sat;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            sat[i]   = &cnt_q[i];
            cnt_d[i] = clr_cnt ? '0 : (ev[i] && !sat[i]) ? cnt_q[i] + 1'b1 : cnt_q[i];
            if (sel == 4'(i)) hit_cnt = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_sat = |sat;
`else
    logic unused_stat;
    assign unused_stat = ^{clr_cnt, sel};
    assign hit_cnt     = '0;
    assign cnt_sat     = 1'b0;
`endif
endmodule
